// File: rtl/priority_scanner.sv
// Priority scanner: accepts a request vector and emits the index of each set bit
// once, in priority order (lowest-first or highest-first), with valid/ready handshake.
module priority_scanner #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             empty_drop
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] pending_s;
  logic             empty_drop_r;
  logic             empty_drop_s;
  logic [IDX_W-1:0] enc_s;
  logic             single_s;
  logic             xfer_s;

  // Later loop hits overwrite earlier ones, so the scan direction picks the winner.
  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) r = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  // Priority encode and single-bit detection on the registered pending vector.
  always_comb begin
    enc_s    = encode(pending_r);
    single_s = (pending_r != ZERO) && ((pending_r & (pending_r - ONE)) == ZERO);
  end

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = (state_r == SCAN);
  assign out_idx    = out_valid ? enc_s : {IDX_W{1'b0}};
  assign out_last   = out_valid & single_s;
  assign empty_drop = empty_drop_r;
  assign xfer_s     = out_valid & out_ready;

  // Next-state, next-pending and empty-drop pulse.
  always_comb begin
    state_s      = state_r;
    pending_s    = pending_r;
    empty_drop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != ZERO) begin
            pending_s = in_vec;
            state_s   = SCAN;
          end else begin
            empty_drop_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // Abort wins over a same-cycle transfer; that transfer still counts as done.
        if (abort) begin
          pending_s = ZERO;
          state_s   = IDLE;
        end else if (xfer_s) begin
          pending_s = pending_r & ~(ONE << enc_s);
          if (single_s) begin
            state_s = IDLE;
          end else begin
            state_s = SCAN;
          end
        end else begin
          state_s = SCAN;
        end
      end
      default: begin
        state_s   = IDLE;
        pending_s = ZERO;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pending_r    <= ZERO;
      empty_drop_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pending_r    <= pending_s;
      empty_drop_r <= empty_drop_s;
    end
  end

endmodule

// File: tb/tb_priority_scanner.sv
// Directed bench for priority_scanner: LSB-first and MSB-first 8-bit instances
// plus a 16-bit LSB-first instance, all sharing clock and reset.
module tb_priority_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_ready, a_abort = 1'b0, a_out_valid, a_out_ready = 1'b0;
  logic       a_out_last, a_empty_drop;
  logic [7:0] a_in_vec = 8'h00;
  logic [2:0] a_out_idx;

  logic       b_in_valid = 1'b0, b_in_ready, b_abort = 1'b0, b_out_valid, b_out_ready = 1'b0;
  logic       b_out_last, b_empty_drop;
  logic [7:0] b_in_vec = 8'h00;
  logic [2:0] b_out_idx;

  logic        c_in_valid = 1'b0, c_in_ready, c_abort = 1'b0, c_out_valid, c_out_ready = 1'b0;
  logic        c_out_last, c_empty_drop;
  logic [15:0] c_in_vec = 16'h0000;
  logic [3:0]  c_out_idx;

  priority_scanner #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
    .abort(a_abort), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
    .out_last(a_out_last), .empty_drop(a_empty_drop));

  priority_scanner #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .abort(b_abort), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_last(b_out_last), .empty_drop(b_empty_drop));

  priority_scanner #(.WIDTH(16), .IDX_W(4), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_vec(c_in_vec),
    .abort(c_abort), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_idx(c_out_idx),
    .out_last(c_out_last), .empty_drop(c_empty_drop));

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_out_idx !== 3'd0 || a_out_last !== 1'b0 || a_empty_drop !== 1'b0 ||
        b_out_valid !== 1'b0 || c_out_valid !== 1'b0 || c_out_idx !== 4'd0 || c_empty_drop !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got a_v=%b a_idx=%0d a_last=%b a_ed=%b b_v=%b c_v=%b c_idx=%0d, want all 0",
               a_out_valid, a_out_idx, a_out_last, a_empty_drop, b_out_valid, c_out_valid, c_out_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready: got a=%b b=%b c=%b a_v=%b, want 1 1 1 0",
               a_in_ready, b_in_ready, c_in_ready, a_out_valid);
    end
  endtask

  task automatic test_lsb_scan;
    logic [2:0] exp_idx [3] = '{3'd1, 3'd3, 3'd6};
    a_in_valid = 1'b1; a_in_vec = 8'h4A; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_vec = 8'h00;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_idx !== exp_idx[k] || a_out_last !== (k == 2) || a_in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL lsb_scan[%0d]: got v=%b idx=%0d last=%b rdy=%b, want v=1 idx=%0d last=%b rdy=0",
                 k, a_out_valid, a_out_idx, a_out_last, a_in_ready, exp_idx[k], (k == 2));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_idx !== 3'd0 || a_out_last !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_scan_done: got v=%b rdy=%b idx=%0d last=%b, want 0 1 0 0",
               a_out_valid, a_in_ready, a_out_idx, a_out_last);
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_msb_scan;
    logic [2:0] exp_idx [3] = '{3'd6, 3'd3, 3'd1};
    b_in_valid = 1'b1; b_in_vec = 8'h4A; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0; b_in_vec = 8'h00;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_out_idx !== exp_idx[k] || b_out_last !== (k == 2)) begin
        n_err++;
        $display("FAIL msb_scan[%0d]: got v=%b idx=%0d last=%b, want v=1 idx=%0d last=%b",
                 k, b_out_valid, b_out_idx, b_out_last, exp_idx[k], (k == 2));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL msb_scan_done: got v=%b rdy=%b, want 0 1", b_out_valid, b_in_ready);
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    a_in_valid = 1'b1; a_in_vec = 8'h81; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_vec = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_idx !== 3'd0 || a_out_last !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: got v=%b idx=%0d last=%b, want 1 0 0", k, a_out_valid, a_out_idx, a_out_last);
      end
      a_out_ready = (k == 3);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd7 || a_out_last !== 1'b1) begin
      n_err++;
      $display("FAIL hold_last: got v=%b idx=%0d last=%b, want 1 7 1", a_out_valid, a_out_idx, a_out_last);
    end
    @(negedge clk);
    a_out_ready = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_done: got v=%b rdy=%b, want 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_empty_drop;
    a_in_valid = 1'b1; a_in_vec = 8'h00;
    @(negedge clk);
    a_in_valid = 1'b0;
    n_cmp++;
    if (a_empty_drop !== 1'b1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL empty_pulse: got ed=%b v=%b rdy=%b, want 1 0 1", a_empty_drop, a_out_valid, a_in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (a_empty_drop !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL empty_after: got ed=%b v=%b rdy=%b, want 0 0 1", a_empty_drop, a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_abort;
    a_in_valid = 1'b1; a_in_vec = 8'hFF; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_vec = 8'h00;
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd0 || a_out_last !== 1'b0) begin
      n_err++;
      $display("FAIL abort_first: got v=%b idx=%0d last=%b, want 1 0 0", a_out_valid, a_out_idx, a_out_last);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd1) begin
      n_err++;
      $display("FAIL abort_second: got v=%b idx=%0d, want 1 1", a_out_valid, a_out_idx);
    end
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0; a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_idx !== 3'd0) begin
        n_err++;
        $display("FAIL abort_idle[%0d]: got v=%b rdy=%b idx=%0d, want 0 1 0", k, a_out_valid, a_in_ready, a_out_idx);
      end
    end
  endtask

  task automatic test_back_to_back;
    a_in_valid = 1'b1; a_in_vec = 8'h03; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_vec = 8'h80;
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd0 || a_out_last !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got v=%b idx=%0d last=%b, want 1 0 0", a_out_valid, a_out_idx, a_out_last);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_idx !== 3'd0 || a_in_ready !== 1'b0 || a_out_last !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ignore_in: got idx=%0d rdy=%b last=%b, want 0 0 0", a_out_idx, a_in_ready, a_out_last);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd1 || a_out_last !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_last: got v=%b idx=%0d last=%b, want 1 1 1", a_out_valid, a_out_idx, a_out_last);
    end
    @(negedge clk);
    a_abort = 1'b1;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_idle: got v=%b rdy=%b, want 0 1", a_out_valid, a_in_ready);
    end
    @(negedge clk);
    a_abort = 1'b0; a_in_valid = 1'b0; a_in_vec = 8'h00;
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd7 || a_out_last !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_vec: got v=%b idx=%0d last=%b, want 1 7 1", a_out_valid, a_out_idx, a_out_last);
    end
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_wide;
    c_in_valid = 1'b1; c_in_vec = 16'h8000; c_out_ready = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0; c_in_vec = 16'h0000;
    n_cmp++;
    if (c_out_valid !== 1'b1 || c_out_idx !== 4'd15 || c_out_last !== 1'b1) begin
      n_err++;
      $display("FAIL wide_single: got v=%b idx=%0d last=%b, want 1 15 1", c_out_valid, c_out_idx, c_out_last);
    end
    @(negedge clk);
    c_in_valid = 1'b1; c_in_vec = 16'hFFFF;
    @(negedge clk);
    c_in_valid = 1'b0; c_in_vec = 16'h0000;
    n_cmp++;
    if (c_out_valid !== 1'b1 || c_out_idx !== 4'd0) begin
      n_err++;
      $display("FAIL wide_ffff_first: got v=%b idx=%0d, want 1 0", c_out_valid, c_out_idx);
    end
    @(negedge clk);
    rst = 1'b1; c_abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; c_abort = 1'b0;
    n_cmp++;
    if (c_out_valid !== 1'b0 || c_out_idx !== 4'd0 || c_out_last !== 1'b0 || c_empty_drop !== 1'b0 ||
        c_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wide_rst: got v=%b idx=%0d last=%b ed=%b rdy=%b, want 0 0 0 0 1",
               c_out_valid, c_out_idx, c_out_last, c_empty_drop, c_in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wide_rst_after: got v=%b rdy=%b, want 0 1", c_out_valid, c_in_ready);
    end
    c_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lsb_scan();
    test_msb_scan();
    test_backpressure();
    test_empty_drop();
    test_abort();
    test_back_to_back();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/priority_scanner.md
PRIORITY_SCANNER -- requirements
Module: priority_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 8: request vector width, legal range 2..64.
REQ-002 SHALL have parameter IDX_W, default 3: index width; must equal ceil(log2(WIDTH)).
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = lowest set bit has priority, 1 = highest set bit has priority.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  request vector offered.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector.
REQ-008 SHALL have port in_vec  input  WIDTH  request vector; bit i = request i.
REQ-009 SHALL have port abort  input  1  discard the remaining pending requests.
REQ-010 SHALL have port out_valid  output  1  out_idx holds a valid index.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_idx.
REQ-012 SHALL have port out_idx  output  IDX_W  encoded index of the current highest-priority pending bit.
REQ-013 SHALL have port out_last  output  1  current index is the final pending bit.
REQ-014 SHALL have port empty_drop  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SCAN.
REQ-016 SHALL hold a WIDTH-bit pending register.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 IDLE: on in_valid=1 with in_vec != 0, SHALL load pending <= in_vec and go to SCAN.
REQ-019 IDLE: on in_valid=1 with in_vec == 0, SHALL stay in IDLE, leave pending at 0, and assert empty_drop in the next cycle only.
REQ-020 SHALL hold out_valid = 1 exactly while in SCAN.
REQ-021 SHALL make out_valid high in the cycle after the accepting edge (latency 1 cycle).
REQ-022 SCAN: SHALL drive out_idx combinationally from registered pending.
- MSB_FIRST=0: index of lowest set bit.
- MSB_FIRST=1: index of highest set bit.
REQ-023 SCAN: SHALL drive out_last = 1 iff pending has exactly one bit set.
REQ-024 SHALL define a transfer as out_valid & out_ready at a rising edge.
- On a transfer, clear the pending bit at out_idx.
- If out_last, go to IDLE.
REQ-025 SHALL sustain one transfer per cycle while out_ready is held high.
REQ-026 SHALL keep out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL drive out_idx = 0 and out_last = 0 whenever out_valid = 0.
REQ-028 SHALL ignore in_valid and in_vec in SCAN; no new vector is accepted until the cycle after returning to IDLE.
REQ-029 abort=1 in SCAN: SHALL clear pending and go to IDLE at that edge.
- A transfer in the same cycle counts as completed.
- All other pending bits are discarded.
REQ-030 SHALL ignore abort in IDLE.
REQ-031 SHALL ensure out_idx < WIDTH for every transfer; each set bit of an accepted vector is emitted exactly once unless aborted or reset.

Reset
REQ-032 rst=1 at an edge SHALL force state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, empty_drop=0.
REQ-033 rst SHALL take priority over in_valid, abort and any transfer in the same cycle.
REQ-034 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-035 rst mid-SCAN SHALL discard pending with no further out_valid.

Verification
REQ-036 WIDTH=8, MSB_FIRST=0, in_vec=8'b0100_1010, out_ready=1 -> out_idx 1,3,6 on consecutive cycles; out_last only with 6; in_ready=1 next cycle.
REQ-037 MSB_FIRST=1, same vector -> out_idx 6,3,1; out_last with 1.
REQ-038 in_vec=8'h81, out_ready=0 for 3 cycles then 1 -> out_idx=0 held 4 cycles, then 7 with out_last=1.
REQ-039 in_vec=8'h00 accepted -> empty_drop high exactly 1 cycle; out_valid stays 0; in_ready stays 1.
REQ-040 in_vec=8'hFF, abort asserted with the 2nd transfer -> out_idx 0,1 emitted, then IDLE, no further out_valid.
REQ-041 WIDTH=16, IDX_W=4, in_vec=16'h8000 -> single out_idx=15 with out_last=1; rst asserted mid-SCAN on 16'hFFFF -> all outputs 0 next cycle.
